// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and helpers for the I2S master.
//   FORMAT_I2S / FORMAT_LJ : values of the FORMAT parameter
//   cnt_w(n)               : bit width of a counter that spans 0..n-1
package i2s_pkg;

  localparam int FORMAT_I2S = 0;
  localparam int FORMAT_LJ  = 1;

  // Width of a counter that must hold 0..n-1. The result is never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: toggle divider that produces a registered square wave in the clk domain.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   en_i   : run when high; when low the counter and the output are held at 0
//   clk_o  : divided clock; it toggles every HALF clk cycles
//   rise_o : high in the cycle before clk_o goes 0->1
//   fall_o : high in the cycle before clk_o goes 1->0
// Downstream logic that registers on rise_o/fall_o changes at the same clk edge as clk_o.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_w(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = wrap && !clk_q;
  assign fall_o = wrap && clk_q;

endmodule

// File: rtl/i2s_master_if.sv
// i2s_master_if: I2S / left-justified master. All codec clocks are registered outputs of the clk domain.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   enable                : run when high; when low the clocks and serial data are forced to 0
//   tx_l, tx_r, tx_valid  : playback pair and its valid flag
//   tx_ready              : holding register empty
//   tx_underrun           : one-cycle pulse when a frame starts with the holding register empty
//   rx_l, rx_r, rx_valid  : captured pair and a one-cycle pulse at each frame start after the first
//   aud_mclk/bclk/lrc     : codec master clock, bit clock and word select (0 = left)
//   aud_dacdat/adcdat     : serial playback output and serial capture input
module i2s_master_if
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF = 4,
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 32,
  parameter int DATA_W    = 24,
  parameter int FORMAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] tx_l,
  input  logic [DATA_W-1:0] tx_r,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_l,
  output logic [DATA_W-1:0] rx_r,
  output logic              rx_valid,
  output logic              aud_mclk,
  output logic              aud_bclk,
  output logic              aud_lrc,
  output logic              aud_dacdat,
  input  logic              aud_adcdat
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int IW    = cnt_w(FRAME);
  localparam int D_INT = (FORMAT == FORMAT_I2S) ? 1 : 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME - 1);
  localparam logic [IW-1:0] SLOT     = IW'(SLOT_BITS);
  localparam logic [IW-1:0] DOFS     = IW'(D_INT);
  localparam logic [IW-1:0] DEND     = IW'(D_INT + DATA_W);

  logic bclk_rise, bclk_fall;
  logic mclk_rise_unused, mclk_fall_unused;

  i2s_clk_div #(.HALF(MCLK_HALF)) u_mclk_div (
    .clk_i (clk), .rst_ni(rst_n), .en_i(enable),
    .clk_o (aud_mclk), .rise_o(mclk_rise_unused), .fall_o(mclk_fall_unused)
  );

  i2s_clk_div #(.HALF(BCLK_HALF)) u_bclk_div (
    .clk_i (clk), .rst_ni(rst_n), .en_i(enable),
    .clk_o (aud_bclk), .rise_o(bclk_rise), .fall_o(bclk_fall)
  );

  logic [IW-1:0]     idx_q, idx_d;
  logic              lrc_q, lrc_d, dac_q, dac_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] txs_l_q, txs_l_d, txs_r_q, txs_r_d;
  logic [DATA_W-1:0] rxs_l_q, rxs_l_d, rxs_r_q, rxs_r_d;
  logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic              rxv_q, rxv_d, und_q, und_d, seen_q, seen_d;

  logic [IW-1:0]     idx_nx, pos_cur, pos_nx;
  logic [DATA_W-1:0] word_l, word_r;
  logic              frame_start;

  function automatic logic [IW-1:0] slot_pos(input logic [IW-1:0] idx);
    return (idx >= SLOT) ? idx - SLOT : idx;
  endfunction

  // p + 1 > DOFS is p >= DOFS without an always-true compare when DOFS is 0.
  function automatic logic in_data(input logic [IW-1:0] p);
    return ((p + IW'(1)) > DOFS) && (p < DEND);
  endfunction

  // Bit of word transmitted at slot position p, MSB at the first data position.
  function automatic logic sel_bit(input logic [DATA_W-1:0] word, input logic [IW-1:0] p);
    logic [DATA_W-1:0] shifted;
    shifted = word >> (IW'(DATA_W - 1) - (p - DOFS));
    return shifted[0];
  endfunction

  assign idx_nx      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign frame_start = bclk_fall && (idx_q == LAST_IDX);
  assign pos_cur     = slot_pos(idx_q);
  assign pos_nx      = slot_pos(idx_nx);

  always_comb begin
    idx_d       = idx_q;
    lrc_d       = lrc_q;
    dac_d       = dac_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    txs_l_d     = txs_l_q;
    txs_r_d     = txs_r_q;
    rxs_l_d     = rxs_l_q;
    rxs_r_d     = rxs_r_q;
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    seen_d      = seen_q;
    rxv_d       = 1'b0;
    und_d       = 1'b0;
    word_l      = txs_l_q;
    word_r      = txs_r_q;

    if (!enable) begin
      idx_d   = LAST_IDX;
      lrc_d   = 1'b0;
      dac_d   = 1'b0;
      txs_l_d = '0;
      txs_r_d = '0;
      rxs_l_d = '0;
      rxs_r_d = '0;
      seen_d  = 1'b0;
    end else begin
      if (bclk_rise && in_data(pos_cur)) begin
        if (idx_q < SLOT) rxs_l_d = {rxs_l_q[DATA_W-2:0], aud_adcdat};
        else              rxs_r_d = {rxs_r_q[DATA_W-2:0], aud_adcdat};
      end
      if (bclk_fall) begin
        if (frame_start) begin
          if (hold_full_q) begin
            word_l = hold_l_q;
            word_r = hold_r_q;
          end else begin
            word_l = '0;
            word_r = '0;
            und_d  = 1'b1;
          end
          txs_l_d     = word_l;
          txs_r_d     = word_r;
          hold_full_d = 1'b0;
          // The very first frame after enable has no complete capture behind it.
          if (seen_q) begin
            rx_l_d = rxs_l_q;
            rx_r_d = rxs_r_q;
            rxv_d  = 1'b1;
          end
          seen_d  = 1'b1;
          rxs_l_d = '0;
          rxs_r_d = '0;
        end
        // lrc and dacdat are computed for the new index so they move with the bclk edge.
        idx_d = idx_nx;
        lrc_d = (idx_nx >= SLOT);
        dac_d = in_data(pos_nx) && sel_bit((idx_nx >= SLOT) ? word_r : word_l, pos_nx);
      end
    end

    // Accept lands after any frame-start load, so a same-cycle pair waits for the next frame.
    if (tx_valid && !hold_full_q) begin
      hold_l_d    = tx_l;
      hold_r_d    = tx_r;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= LAST_IDX;
      lrc_q       <= 1'b0;
      dac_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      txs_l_q     <= '0;
      txs_r_q     <= '0;
      rxs_l_q     <= '0;
      rxs_r_q     <= '0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      rxv_q       <= 1'b0;
      und_q       <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      lrc_q       <= lrc_d;
      dac_q       <= dac_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      txs_l_q     <= txs_l_d;
      txs_r_q     <= txs_r_d;
      rxs_l_q     <= rxs_l_d;
      rxs_r_q     <= rxs_r_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      rxv_q       <= rxv_d;
      und_q       <= und_d;
      seen_q      <= seen_d;
    end
  end

  assign tx_ready    = !hold_full_q;
  assign tx_underrun = und_q;
  assign rx_l        = rx_l_q;
  assign rx_r        = rx_r_q;
  assign rx_valid    = rxv_q;
  assign aud_lrc     = lrc_q;
  assign aud_dacdat  = dac_q;

endmodule
